// File: rtl/manchester_pkg.sv
// Shared line-coding constants and the deframer state encoding for the
// Manchester transmit/receive chain (escaper, preamble, deframer).
package manchester_pkg;

  localparam logic [7:0] FLAG_CODE     = 8'h7E;
  localparam logic [7:0] ESC_CODE      = 8'h7D;
  localparam logic [7:0] ESC_XOR_MASK  = 8'h20;
  localparam logic [7:0] PREAMBLE_CODE = 8'h55;

  // ST_ESC: the previous byte was an escape prefix, the next one is un-stuffed
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_DATA = 2'd1,
    ST_ESC  = 2'd2
  } deframer_state_t;

endpackage

// File: rtl/manchester_deframer.sv
// Receive-side deframer: hunts for the start flag, removes byte stuffing and
// turns flag-delimited frames into an AXI-Stream with tlast and an error tuser.
module manchester_deframer
  import manchester_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    FRAME_SIZE = 8,
  parameter int                    MAX_LEN    = 255,
  parameter logic [DATA_WIDTH-1:0] FLAG       = FLAG_CODE,
  parameter logic [DATA_WIDTH-1:0] ESC        = ESC_CODE,
  parameter logic [DATA_WIDTH-1:0] ESC_XOR    = ESC_XOR_MASK
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_ok,
  output logic                  frame_err
);

  localparam int               CNT_W     = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_SIZE);

  deframer_state_t       state_reg;
  logic [DATA_WIDTH-1:0] pend_data_reg;
  logic                  pend_valid_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  err_reg;
  logic                  run_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_valid_reg;
  logic                  out_last_reg;
  logic                  out_user_reg;
  logic                  frame_ok_reg;
  logic                  frame_err_reg;

  logic                  in_ready;
  logic                  in_fire;
  logic                  is_flag;
  logic                  is_esc;
  logic                  payload_fire;
  logic [DATA_WIDTH-1:0] payload_byte;
  logic                  length_err;
  logic                  close_bad;

  // run_reg keeps the input closed until the first clock after reset release
  assign in_ready = run_reg && (!out_valid_reg || m_axis_tready);
  assign in_fire  = s_axis_tvalid && in_ready;
  assign is_flag  = (s_axis_tdata == FLAG);
  assign is_esc   = (s_axis_tdata == ESC);

  always_comb begin
    payload_fire = 1'b0;
    payload_byte = s_axis_tdata;
    if (in_fire) begin
      case (state_reg)
        ST_DATA: payload_fire = !is_flag && !is_esc;
        ST_ESC: begin
          payload_fire = !is_flag;
          payload_byte = s_axis_tdata ^ ESC_XOR;
        end
        default: payload_fire = 1'b0;
      endcase
    end
  end

  assign length_err = ((FRAME_SIZE != 0) && (count_reg != FRAME_CNT)) || err_reg;
  assign close_bad  = err_reg || length_err;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg      <= ST_HUNT;
      pend_data_reg  <= '0;
      pend_valid_reg <= 1'b0;
      count_reg      <= '0;
      err_reg        <= 1'b0;
      run_reg        <= 1'b0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      out_user_reg   <= 1'b0;
      frame_ok_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      run_reg       <= 1'b1;
      frame_ok_reg  <= 1'b0;
      frame_err_reg <= 1'b0;

      if (out_valid_reg && m_axis_tready) begin
        out_valid_reg <= 1'b0;
      end

      if (in_fire) begin
        case (state_reg)
          ST_HUNT: begin
            if (is_flag) begin
              state_reg      <= ST_DATA;
              pend_valid_reg <= 1'b0;
              count_reg      <= '0;
              err_reg        <= 1'b0;
            end
          end

          ST_DATA: begin
            if (is_flag) begin
              if (pend_valid_reg) begin
                out_data_reg   <= pend_data_reg;
                out_valid_reg  <= 1'b1;
                out_last_reg   <= 1'b1;
                out_user_reg   <= close_bad;
                frame_ok_reg   <= !close_bad;
                frame_err_reg  <= close_bad;
                pend_valid_reg <= 1'b0;
                state_reg      <= ST_HUNT;
              end else begin
                // empty frame or repeated flag: restart the frame in place
                count_reg <= '0;
                err_reg   <= 1'b0;
              end
            end else if (is_esc) begin
              state_reg <= ST_ESC;
            end
          end

          ST_ESC: begin
            if (is_flag) begin
              if (pend_valid_reg) begin
                out_data_reg  <= pend_data_reg;
                out_valid_reg <= 1'b1;
                out_last_reg  <= 1'b1;
                out_user_reg  <= 1'b1;
                frame_err_reg <= 1'b1;
              end
              pend_valid_reg <= 1'b0;
              count_reg      <= '0;
              err_reg        <= 1'b0;
            end
            state_reg <= ST_DATA;
          end

          default: state_reg <= ST_HUNT;
        endcase
      end

      // Emitting the previous byte here is what makes "last" known one byte late
      if (payload_fire) begin
        if (pend_valid_reg) begin
          out_data_reg  <= pend_data_reg;
          out_valid_reg <= 1'b1;
          out_last_reg  <= 1'b0;
          out_user_reg  <= 1'b0;
        end
        pend_data_reg  <= payload_byte;
        pend_valid_reg <= 1'b1;
        if (count_reg == MAX_CNT) begin
          err_reg <= 1'b1;
        end else begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end
  end

  assign s_axis_tready = in_ready;
  assign m_axis_tdata  = out_data_reg;
  assign m_axis_tvalid = out_valid_reg;
  assign m_axis_tlast  = out_last_reg;
  assign m_axis_tuser  = out_user_reg;
  assign frame_ok      = frame_ok_reg;
  assign frame_err     = frame_err_reg;

endmodule
